rx_ingress_fifo: RTL
====================

// Module: rx_ingress_fifo
// PURPOSE
//  Byte FIFO directly upstream of an rx port. Buffers link bytes and drives the
//  rx_vld/rx_data/rx_rdy handshake, holding data stable until accepted.
//  Reports a level watermark, and an idle flag consumed by power control.
//  Flushed by a CSR write.
// PARAMETERS
//  DEPTH     8   entries; power of two, >=2
//  AW        3   log2(DEPTH)
//  HI_WM     6   out_hiwm asserts when count >= HI_WM
//  IDLE_CYC  16  empty, quiet cycles before idle asserts; 1..255
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     asynchronous, active-low reset
//  in_vld     in   1     link byte valid
//  in_data    in   8     link byte
//  in_par     in   1     even-parity bit (only with PARITY_CHECK_EN)
//  in_rdy     out  1     FIFO can accept
//  rx_vld     out  1     byte available to rx
//  rx_data    out  8     head byte
//  rx_rdy     in   1     rx accepts head byte
//  flush      in   1     CSR-decoded flush strobe, one cycle
//  count      out  AW+1  occupancy, 0..DEPTH
//  out_hiwm   out  1     count >= HI_WM
//  idle       out  1     FIFO idle, to pwr_ctrl
//  err_cnt    out  8     parity error count, saturating
// BEHAVIOUR
//  Reset values
//   - Pointers, count and err_cnt are 0; idle counter is 0.
//   - rx_vld=0, rx_data=8'h00, out_hiwm=0, idle=0.
//   - in_rdy=1 from the first cycle after reset release.
//  Push and pop
//   - in_rdy = !full && !flush. Push on in_vld && in_rdy; writes mem[wr_ptr]; wr_ptr++.
//   - rx_vld = !empty. rx_data = mem[rd_ptr]; reads 8'h00 when empty.
//   - Pop on rx_vld && rx_rdy; rd_ptr++.
//   - Latency: a byte pushed at edge N gives rx_vld=1 after edge N. No bypass.
//  Stability
//   - While rx_vld && !rx_rdy, rx_vld and rx_data stay unchanged. Pushes never
//     write the rd_ptr slot while the FIFO is non-empty.
//  Pointers and count
//   - Pointers are AW bits and wrap DEPTH-1 -> 0. count is tracked explicitly.
//   - full = (count==DEPTH); empty = (count==0).
//  Simultaneous events
//   - Push and pop together: count unchanged, both pointers advance. Legal at
//     any non-empty, non-full level.
//   - When full, in_rdy=0, so no push occurs; a pop frees a slot from the next cycle.
//   - When empty, only a push can occur; no pop.
//  Flush
//   - Pointers and count go to 0 on the next edge.
//   - A push or pop in the flush cycle is discarded; in_rdy=0 that cycle.
//   - Does not clear err_cnt or the idle counter.
//  Idle
//   - An 8-bit counter increments, saturating at IDLE_CYC, while empty && !in_vld.
//   - Any other cycle clears it to 0.
//   - idle = (counter == IDLE_CYC), registered. Deasserts the edge after in_vld rises.
//  Reset mid-operation
//   - Asserting reset clears all state immediately. Buffered bytes are lost.
// CONFIGURATION
//  PARITY_CHECK_EN
//   - Defined: in_par exists. A handshaked byte with ^{in_data,in_par}==1 is
//     consumed (in_rdy protocol unchanged) but not written.
//   - Each such byte increments err_cnt, saturating at 8'hFF.
//   - Undefined: in_par is absent, every handshaked byte is written, err_cnt=8'h00.
// TESTING
//  1. Push 8'hA5, 8'h3C with rx_rdy=0 -> rx_vld=1 next cycle; rx_data=A5 held;
//     count=2. Then rx_rdy=1 -> A5, then 3C, in order.
//  2. Push 8 bytes 0..7 -> count=8, in_rdy=0, out_hiwm=1 from count 6.
//     Pop one -> in_rdy=1 next cycle. Push 8 -> read order 1..8 (wrap).
//  3. count=4 with push and pop every cycle for 20 cycles -> count stays 4; data in order.
//  4. count=5, then flush with in_vld=1 in the same cycle -> count=0, rx_vld=0
//     next cycle; that byte never appears.
//  5. Empty with in_vld=0 for 16 cycles -> idle=1. in_vld=1 -> idle=0 after next edge.
//  6. PARITY_CHECK_EN: push 8'h01/par 0 (bad), then 8'h03/par 0 (good) ->
//     err_cnt=1, count=1, rx_data=8'h03.
//     Reset asserted mid-stream -> count=0, err_cnt=0.

Source files
------------

// File: rtl/rx_ingress_fifo.sv
// Byte FIFO feeding an rx port: valid/ready handshake, level watermark and idle flag.
// Optional macro PARITY_CHECK_EN adds in_par and drops (and counts) bad-parity bytes.
module rx_ingress_fifo #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int HI_WM    = 6,
  parameter int IDLE_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_vld,
  input  logic [7:0]    in_data,
`ifdef PARITY_CHECK_EN
  input  logic          in_par,
`endif
  output logic          in_rdy,
  output logic          rx_vld,
  output logic [7:0]    rx_data,
  input  logic          rx_rdy,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          out_hiwm,
  output logic          idle,
  output logic [7:0]    err_cnt
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] HI_WM_C = HI_WM[AW:0];
  localparam logic [7:0]  IDLE_C  = IDLE_CYC[7:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    idle_cnt, idle_cnt_nxt;
  logic          full, empty, push, pop, par_ok, wr_en;

  always_comb begin
    full     = (count == DEPTH_C);
    empty    = (count == '0);
    in_rdy   = !full && !flush;
    rx_vld   = !empty;
    rx_data  = empty ? 8'h00 : mem[rd_ptr];
    push     = in_vld && in_rdy;
    pop      = rx_vld && rx_rdy && !flush;
`ifdef PARITY_CHECK_EN
    par_ok   = ~^{in_data, in_par};
`else
    par_ok   = 1'b1;
`endif
    wr_en    = push && par_ok;
    out_hiwm = (count >= HI_WM_C);
    idle_cnt_nxt = 8'h00;
    if (empty && !in_vld)
      idle_cnt_nxt = (idle_cnt == IDLE_C) ? idle_cnt : idle_cnt + 8'h01;
  end

  // Storage has no reset; rx_data is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      idle_cnt <= 8'h00;
      idle     <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      idle     <= (idle_cnt_nxt == IDLE_C);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && !pop)
          count <= count + 1'b1;
        else if (!wr_en && pop)
          count <= count - 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // A bad-parity byte is still handshaked so the link never stalls on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_cnt <= 8'h00;
    else if (push && !par_ok && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'h01;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule
